// File: rtl/cci_mpf_active_req_tracker_pkg.sv
// Shared types and the saturating step used by every channel counter.
package cci_mpf_active_req_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ACK   = 2'd2
    } t_drain_state;

    typedef struct packed {
        logic [31:0] cnt;
        logic        ovf;
        logic        udf;
    } t_sat_step;

    // One counter step. The count is carried at 32 bits so a single function
    // serves every counter width; cnt_max is the saturation value for the caller.
    function automatic t_sat_step sat_step(input logic [31:0] cnt,
                                           input logic        incr,
                                           input logic        decr,
                                           input logic [31:0] cnt_max);
        t_sat_step r;
        r.cnt = cnt;
        r.ovf = 1'b0;
        r.udf = 1'b0;
        if (incr && !decr) begin
            if (cnt >= cnt_max) r.ovf = 1'b1;
            else                r.cnt = cnt + 32'd1;
        end else if (decr && !incr) begin
            if (cnt == 32'd0) r.udf = 1'b1;
            else              r.cnt = cnt - 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cci_mpf_active_req_tracker_if.sv
// Event strobes in, per-channel status and drain handshake out.
interface cci_mpf_active_req_tracker_if #(
    parameter int N_CHANNELS = 2,
    parameter int CNT_W      = 11
);
    logic [N_CHANNELS-1:0]       incr;
    logic [N_CHANNELS-1:0]       decr;
    logic                        peak_clr;
    logic                        drain_req;
    logic [N_CHANNELS*CNT_W-1:0] active_cnt;
    logic [N_CHANNELS*CNT_W-1:0] peak_cnt;
    logic [N_CHANNELS-1:0]       not_empty;
    logic [N_CHANNELS-1:0]       almost_full;
    logic                        all_empty;
    logic                        block_new;
    logic                        drain_ack;
    logic [N_CHANNELS-1:0]       err_overflow;
    logic [N_CHANNELS-1:0]       err_underflow;

    modport master (
        output incr, decr, peak_clr, drain_req,
        input  active_cnt, peak_cnt, not_empty, almost_full, all_empty,
               block_new, drain_ack, err_overflow, err_underflow
    );

    modport slave (
        input  incr, decr, peak_clr, drain_req,
        output active_cnt, peak_cnt, not_empty, almost_full, all_empty,
               block_new, drain_ack, err_overflow, err_underflow
    );
endinterface

// File: rtl/cci_mpf_active_req_tracker_counter.sv
// One channel: saturating active count, high-water mark, almost-full and sticky errors.
module cci_mpf_active_req_counter
    import cci_mpf_active_req_pkg::*;
#(
    parameter int CNT_W        = 11,
    parameter int AF_THRESHOLD = 1008
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             incr,
    input  logic             decr,
    input  logic             peak_clr,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_next,
    output logic [CNT_W-1:0] peak,
    output logic             not_empty,
    output logic             almost_full,
    output logic             err_overflow,
    output logic             err_underflow
);
    localparam logic [31:0]      CNT_MAX = (32'd1 << CNT_W) - 32'd1;
    localparam logic [CNT_W-1:0] AF_LVL  = CNT_W'(AF_THRESHOLD);

    t_sat_step        step;
    logic [CNT_W-1:0] cnt_d, cnt_q, peak_d, peak_q;
    logic             not_empty_d, not_empty_q, almost_full_d, almost_full_q;
    logic             err_ovf_d, err_ovf_q, err_udf_d, err_udf_q;

    // Next count, peak and status flags from this cycle's strobes.
    always_comb begin
        step          = sat_step(32'(cnt_q), incr, decr, CNT_MAX);
        cnt_d         = CNT_W'(step.cnt);
        peak_d        = (peak_clr || (cnt_d > peak_q)) ? cnt_d : peak_q;
        not_empty_d   = incr || (cnt_q != '0);
        almost_full_d = (cnt_d >= AF_LVL);
        err_ovf_d     = err_ovf_q || step.ovf;
        err_udf_d     = err_udf_q || step.udf;
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q         <= '0;
            peak_q        <= '0;
            not_empty_q   <= 1'b0;
            almost_full_q <= 1'b0;
            err_ovf_q     <= 1'b0;
            err_udf_q     <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            peak_q        <= peak_d;
            not_empty_q   <= not_empty_d;
            almost_full_q <= almost_full_d;
            err_ovf_q     <= err_ovf_d;
            err_udf_q     <= err_udf_d;
        end
    end

    assign cnt           = cnt_q;
    assign cnt_next      = cnt_d;
    assign peak          = peak_q;
    assign not_empty     = not_empty_q;
    assign almost_full   = almost_full_q;
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_udf_q;
endmodule

// File: rtl/cci_mpf_active_req_tracker.sv
// N-channel outstanding-request tracker with a drain handshake.
//
//   state | meaning
//   IDLE  | normal operation, new requests allowed
//   DRAIN | block_new held, waiting for every channel to reach zero
//   ACK   | one-cycle drain_ack, block_new still held
module cci_mpf_active_req_tracker
    import cci_mpf_active_req_pkg::*;
#(
    parameter int N_CHANNELS      = 2,
    parameter int MAX_ACTIVE_REQS = 1024,
    parameter int AF_THRESHOLD    = MAX_ACTIVE_REQS - 16,
    parameter int CNT_W           = $clog2(MAX_ACTIVE_REQS) + 1
) (
    input logic                              clk,
    input logic                              reset_n,
    cci_mpf_active_req_tracker_if.slave      tr
);
    logic [N_CHANNELS-1:0][CNT_W-1:0] cnt_arr, cnt_next_arr, peak_arr;
    logic         all_zero, all_next_zero;
    logic         all_empty_d, all_empty_q;
    t_drain_state state_d, state_q;

    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
        cci_mpf_active_req_counter #(
            .CNT_W        (CNT_W),
            .AF_THRESHOLD (AF_THRESHOLD)
        ) u_cnt (
            .clk           (clk),
            .reset_n       (reset_n),
            .incr          (tr.incr[i]),
            .decr          (tr.decr[i]),
            .peak_clr      (tr.peak_clr),
            .cnt           (cnt_arr[i]),
            .cnt_next      (cnt_next_arr[i]),
            .peak          (peak_arr[i]),
            .not_empty     (tr.not_empty[i]),
            .almost_full   (tr.almost_full[i]),
            .err_overflow  (tr.err_overflow[i]),
            .err_underflow (tr.err_underflow[i])
        );
    end

    // Cross-channel reductions feeding all_empty and the drain condition.
    always_comb begin
        all_zero      = 1'b1;
        all_next_zero = 1'b1;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (cnt_arr[i] != '0)      all_zero      = 1'b0;
            if (cnt_next_arr[i] != '0) all_next_zero = 1'b0;
        end
        all_empty_d = all_zero && (tr.incr == '0);
    end

    // Drain next-state; requests arriving outside IDLE are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tr.drain_req) state_d = DRAIN;
            DRAIN:   if (all_next_zero && (tr.incr == '0)) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM and all_empty registers; all_empty comes out of reset set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            all_empty_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            all_empty_q <= all_empty_d;
        end
    end

    assign tr.active_cnt = cnt_arr;
    assign tr.peak_cnt   = peak_arr;
    assign tr.all_empty  = all_empty_q;
    assign tr.block_new  = (state_q != IDLE);
    assign tr.drain_ack  = (state_q == ACK);
endmodule
